zeroheti_apb_bridge: RTL

ZEROHETI_APB_BRIDGE -- requirements
Module: zeroheti_apb_bridge

---
 rtl/zeroheti_pkg.sv | 30 +++
 rtl/zeroheti_apb_decoder.sv | 32 +++
 rtl/zeroheti_apb_bridge.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/zeroheti_pkg.sv
// Shared definitions for the zeroheti APB bridge.
//   apb_rule_t      : inclusive {base, last} address window of one APB subordinate
//   DefaultApbRules : address map of the four default subordinates
//                     (index 0 clic, 1 mtimer, 2 uart, 3 gpio)
//   apb_state_e     : bridge FSM state encoding
package zeroheti_pkg;

    typedef struct packed {
        logic [31:0] base;
        logic [31:0] last;
    } apb_rule_t;

    localparam int unsigned DefaultNumSbr = 4;

    // Concatenation order puts index 3 in the most significant slot.
    localparam apb_rule_t [DefaultNumSbr-1:0] DefaultApbRules = {
        apb_rule_t'{base: 32'h0003_2000, last: 32'h0003_2FFF},  // 3: gpio
        apb_rule_t'{base: 32'h0003_1000, last: 32'h0003_1FFF},  // 2: uart
        apb_rule_t'{base: 32'h0003_0000, last: 32'h0003_0FFF},  // 1: mtimer
        apb_rule_t'{base: 32'h0005_0000, last: 32'h0005_FFFF}   // 0: clic
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

endpackage

// File: rtl/zeroheti_apb_decoder.sv
// Combinational address decoder for the zeroheti APB bridge.
// Ports:
//   addr_i : byte address to decode
//   idx_o  : index of the matching rule (0 when no rule matches)
//   hit_o  : 1 when some rule matches
// When rules overlap, the lowest-index rule wins.
module zeroheti_apb_decoder
    import zeroheti_pkg::*;
#(
    parameter int unsigned NumSbr = 4,
    parameter apb_rule_t [NumSbr-1:0] Rules = DefaultApbRules,
    parameter int unsigned IdxW = (NumSbr > 1) ? $clog2(NumSbr) : 1
) (
    input  logic [31:0]     addr_i,
    output logic [IdxW-1:0] idx_o,
    output logic            hit_o
);

    // Scan from the highest index down so the lowest matching index is
    // the last one written.
    always_comb begin
        idx_o = '0;
        hit_o = 1'b0;
        for (int i = NumSbr - 1; i >= 0; i--) begin
            if ((addr_i >= Rules[i].base) && (addr_i <= Rules[i].last)) begin
                idx_o = IdxW'(i);
                hit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/zeroheti_apb_bridge.sv
// OBI to APB bridge with one outstanding transaction.
// Ports:
//   clk_i, rst_ni             : clock, asynchronous active-low reset
//   obi_req_i / obi_gnt_o     : OBI request; grant is req while IDLE, else 0
//   obi_addr_i, obi_we_i,
//   obi_be_i, obi_wdata_i     : OBI request payload
//   obi_rvalid_o, obi_rdata_o,
//   obi_err_o                 : one-cycle OBI response
//   paddr_o, psel_o, penable_o,
//   pwrite_o, pwdata_o, pstrb_o : APB request (psel_o one-hot)
//   prdata_i, pready_i,
//   pslverr_i                 : per-subordinate APB response, packed by index
// Handshake: a request is accepted in the cycle obi_req_i and obi_gnt_o are
// both high; exactly one obi_rvalid_o pulse follows for every accepted
// request unless reset intervenes. On the APB side the selected
// subordinate's pready_i is sampled only while penable_o is high.
// Optional feature: define ZEROHETI_APB_TIMEOUT_EN to bound the ACCESS wait
// to TimeoutCycles cycles; the transfer then ends with an error response.
module zeroheti_apb_bridge
    import zeroheti_pkg::*;
#(
    parameter int unsigned NumSbr = 4,
    parameter apb_rule_t [NumSbr-1:0] Rules = DefaultApbRules,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  obi_req_i,
    output logic                  obi_gnt_o,
    input  logic [31:0]           obi_addr_i,
    input  logic                  obi_we_i,
    input  logic [3:0]            obi_be_i,
    input  logic [31:0]           obi_wdata_i,
    output logic                  obi_rvalid_o,
    output logic [31:0]           obi_rdata_o,
    output logic                  obi_err_o,
    output logic [31:0]           paddr_o,
    output logic [NumSbr-1:0]     psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [31:0]           pwdata_o,
    output logic [3:0]            pstrb_o,
    input  logic [NumSbr*32-1:0]  prdata_i,
    input  logic [NumSbr-1:0]     pready_i,
    input  logic [NumSbr-1:0]     pslverr_i
);

    localparam int unsigned IdxW = (NumSbr > 1) ? $clog2(NumSbr) : 1;

    apb_state_e      state_q;
    logic [IdxW-1:0] sel_q;
    logic [IdxW-1:0] dec_idx;
    logic            dec_hit;
    logic [31:0]     prdata_sel;
    logic            pready_sel;
    logic            pslverr_sel;

`ifdef ZEROHETI_APB_TIMEOUT_EN
    logic [15:0]     timeout_cnt_q;
`endif

    zeroheti_apb_decoder #(
        .NumSbr (NumSbr),
        .Rules  (Rules),
        .IdxW   (IdxW)
    ) u_decoder (
        .addr_i (obi_addr_i),
        .idx_o  (dec_idx),
        .hit_o  (dec_hit)
    );

    // Gated by reset so the grant is low while reset is held.
    assign obi_gnt_o = rst_ni && (state_q == IDLE) && obi_req_i;

    // Only the selected subordinate's response is visible to the FSM.
    always_comb begin
        prdata_sel  = '0;
        pready_sel  = 1'b0;
        pslverr_sel = 1'b0;
        for (int i = 0; i < NumSbr; i++) begin
            if (sel_q == IdxW'(i)) begin
                prdata_sel  = prdata_i[i*32 +: 32];
                pready_sel  = pready_i[i];
                pslverr_sel = pslverr_i[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            sel_q         <= '0;
            obi_rvalid_o  <= 1'b0;
            obi_rdata_o   <= '0;
            obi_err_o     <= 1'b0;
            paddr_o       <= '0;
            psel_o        <= '0;
            penable_o     <= 1'b0;
            pwrite_o      <= 1'b0;
            pwdata_o      <= '0;
            pstrb_o       <= '0;
`ifdef ZEROHETI_APB_TIMEOUT_EN
            timeout_cnt_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (obi_req_i) begin
                        if (dec_hit) begin
                            state_q  <= SETUP;
                            sel_q    <= dec_idx;
                            psel_o   <= NumSbr'(1) << dec_idx;
                            paddr_o  <= obi_addr_i;
                            pwrite_o <= obi_we_i;
                            pwdata_o <= obi_wdata_i;
                            pstrb_o  <= obi_we_i ? obi_be_i : 4'b0000;
`ifdef ZEROHETI_APB_TIMEOUT_EN
                            timeout_cnt_q <= '0;
`endif
                        end else begin
                            // Unmapped address: answer with an error, APB untouched.
                            state_q      <= RESP;
                            obi_rvalid_o <= 1'b1;
                            obi_err_o    <= 1'b1;
                            obi_rdata_o  <= '0;
                        end
                    end
                end
                SETUP: begin
                    state_q   <= ACCESS;
                    penable_o <= 1'b1;
                end
                ACCESS: begin
                    if (pready_sel) begin
                        state_q      <= RESP;
                        psel_o       <= '0;
                        penable_o    <= 1'b0;
                        obi_rvalid_o <= 1'b1;
                        obi_err_o    <= pslverr_sel;
                        obi_rdata_o  <= pwrite_o ? 32'h0 : prdata_sel;
                    end
`ifdef ZEROHETI_APB_TIMEOUT_EN
                    else if (timeout_cnt_q == 16'(TimeoutCycles - 1)) begin
                        // This is the TimeoutCycles-th stalled ACCESS cycle.
                        state_q      <= RESP;
                        psel_o       <= '0;
                        penable_o    <= 1'b0;
                        obi_rvalid_o <= 1'b1;
                        obi_err_o    <= 1'b1;
                        obi_rdata_o  <= '0;
                    end else begin
                        timeout_cnt_q <= timeout_cnt_q + 16'd1;
                    end
`endif
                end
                RESP: begin
                    state_q      <= IDLE;
                    obi_rvalid_o <= 1'b0;
                    obi_err_o    <= 1'b0;
                    obi_rdata_o  <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
